// File: rtl/jfif_pkg.sv
// Shared types and constants for the JFIF stream framer: FSM states, marker
// bytes and the header image served by the header ROM.
package jfif_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEAD,
        DATA,
        RST,
        EOI
    } state_t;

    localparam logic [7:0] MRK_PREFIX = 8'hFF;
    localparam logic [7:0] MRK_EOI    = 8'hD9;
    localparam logic [7:0] MRK_RST0   = 8'hD0;

    // Header image: SOI at addresses 0..1, then the table/SOS body bytes.
    function automatic logic [7:0] hdr_byte(input int unsigned a);
        if (a == 0) return MRK_PREFIX;
        if (a == 1) return 8'hD8;
        return 8'((a * 37 + 11) % 256);
    endfunction

endpackage

// File: rtl/jfif_hdr_rom.sv
// Header ROM: HDR_LEN bytes, synchronous read with one cycle of latency.
// Addresses at or beyond HDR_LEN read as zero.
module jfif_hdr_rom
    import jfif_pkg::*;
#(
    parameter int HDR_LEN = 607,
    parameter int HDR_AW  = 10
) (
    input  logic              clk,
    input  logic [HDR_AW-1:0] addr,
    output logic [7:0]        data
);

    always_ff @(posedge clk) begin
        if (int'(addr) < HDR_LEN) data <= hdr_byte(int'(addr));
        else                      data <= 8'h00;
    end

endmodule

// File: rtl/jfif_framer.sv
// JFIF framer: header from ROM, entropy bytes passed through, optional RSTn
// markers every RST_INTERVAL MCUs, FF D9 to close each frame.
module jfif_framer
    import jfif_pkg::*;
#(
    parameter int HDR_LEN      = 607,
    parameter int HDR_AW       = 10,
    parameter int RST_INTERVAL = 0,
    parameter int RST_CW       = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       frame_start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_mcu_end,
    input  logic       in_last,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       frame_done,
    output state_t     fsm_state
);

    localparam logic [HDR_AW-1:0] HDR_LAST = HDR_AW'(HDR_LEN - 1);
    localparam logic [RST_CW-1:0] MCU_LAST = RST_CW'(RST_INTERVAL - 1);

    // Handshakes: a byte moves on a port when valid && ready at the clock edge;
    // a producer holding valid keeps its data stable until that edge.

    state_t            state;
    logic [HDR_AW-1:0] hdr_ptr;
    logic [HDR_AW-1:0] rd_addr;
    logic [7:0]        rom_q;
    logic [RST_CW-1:0] mcu_cnt;
    logic [2:0]        rst_idx;
    logic [1:0]        mrk_pos;
    logic              load;
    logic              rst_hit;

    // The state names the source of the next byte loaded into the output
    // register, so each source hands over with no idle cycle in between.
    assign load      = !out_valid || out_ready;
    assign in_ready  = (state == DATA) && load;
    assign rst_hit   = (RST_INTERVAL != 0) && in_mcu_end && !in_last && (mcu_cnt == MCU_LAST);
    assign busy      = (state != IDLE);
    assign fsm_state = state;

    // hdr_ptr is the address whose byte sits in rom_q; re-reading it holds a stall.
    always_comb begin
        rd_addr = hdr_ptr;
        if (state == IDLE)             rd_addr = '0;
        else if (state == HEAD && load) rd_addr = hdr_ptr + 1'b1;
    end

    jfif_hdr_rom #(
        .HDR_LEN (HDR_LEN),
        .HDR_AW  (HDR_AW)
    ) u_hdr_rom (
        .clk  (sys_clk),
        .addr (rd_addr),
        .data (rom_q)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            out_data   <= 8'h00;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            hdr_ptr    <= '0;
            mcu_cnt    <= '0;
            rst_idx    <= 3'd0;
            mrk_pos    <= 2'd0;
        end else begin
            frame_done <= 1'b0;
            hdr_ptr    <= rd_addr;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state   <= HEAD;
                        mcu_cnt <= '0;
                        rst_idx <= 3'd0;
                        mrk_pos <= 2'd0;
                    end
                end
                HEAD: begin
                    if (load) begin
                        out_data  <= rom_q;
                        out_valid <= 1'b1;
                        if (hdr_ptr == HDR_LAST) state <= DATA;
                    end
                end
                DATA: begin
                    if (load) begin
                        out_valid <= in_valid;
                        if (in_valid) begin
                            out_data <= in_data;
                            if (in_mcu_end) mcu_cnt <= rst_hit ? '0 : mcu_cnt + 1'b1;
                            if (in_last)      state <= EOI;
                            else if (rst_hit) state <= RST;
                        end
                    end
                end
                RST: begin
                    if (load) begin
                        out_valid <= 1'b1;
                        if (mrk_pos == 2'd0) begin
                            out_data <= MRK_PREFIX;
                            mrk_pos  <= 2'd1;
                        end else begin
                            out_data <= MRK_RST0 | {5'd0, rst_idx};
                            rst_idx  <= rst_idx + 3'd1;
                            mrk_pos  <= 2'd0;
                            state    <= DATA;
                        end
                    end
                end
                EOI: begin
                    // mrk_pos 2 means D9 is on the output waiting to be taken.
                    if (load) begin
                        case (mrk_pos)
                            2'd0: begin
                                out_data  <= MRK_PREFIX;
                                out_valid <= 1'b1;
                                mrk_pos   <= 2'd1;
                            end
                            2'd1: begin
                                out_data  <= MRK_EOI;
                                out_valid <= 1'b1;
                                mrk_pos   <= 2'd2;
                            end
                            default: begin
                                out_valid  <= 1'b0;
                                frame_done <= 1'b1;
                                mrk_pos    <= 2'd0;
                                state      <= IDLE;
                            end
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
